fetch_stage: RTL and testbench

Instruction-fetch front end for the 16-bit WISC CPU. It sits directly upstream of decode and owns the PC register. It issues one outstanding request at a time to a variable-latency instruction memory (cache or miss path). It holds the IF/ID pipeline register that decode consumes, and it handles decode back-pressure, branch/BR redirects and HLT detection.

---
 rtl/wisc_pkg.sv | 27 ++
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage_ifid_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC opcode constants, fetch state encoding and helpers
// Contents:
//   OP_B, OP_BR, OP_PCS, OP_HLT : instr[15:12] opcode values
//   NOP_INSTR                   : encoding used for an empty IF/ID register
//   fetch_state_e               : fetch front-end FSM states
//   opcode_is()                 : compare instr[15:12] against an opcode
package wisc_pkg;

    localparam logic [3:0]  OP_B      = 4'hC;
    localparam logic [3:0]  OP_BR     = 4'hD;
    localparam logic [3:0]  OP_PCS    = 4'hE;
    localparam logic [3:0]  OP_HLT    = 4'hF;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    function automatic logic opcode_is(input logic [15:0] instr, input logic [3:0] op);
        return instr[15:12] == op;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus
// Signals:
//   imem_req   : fetch request, held until imem_valid
//   imem_addr  : fetch address
//   imem_rdata : instruction word, valid with imem_valid
//   imem_valid : one-cycle response strobe
// Modports: master (fetch side), slave (memory side)
interface fetch_stage_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with load and flush enables
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : capture instr_i/pc_plus2_i and mark valid
//   flush_i        : turn IF/ID into a bubble (wins over load_i)
//   instr_i        : instruction to capture
//   pc_plus2_i     : PC+2 of instr_i
//   instr_o        : registered instruction
//   pc_plus2_o     : registered PC+2
//   valid_o        : IF/ID holds a real instruction
module ifid_reg
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        if (flush_i) begin
            // A bubble keeps the old payload; only valid matters to decode.
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_plus2_d = pc_plus2_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - WISC instruction-fetch front end: PC, fetch FSM, skid buffer, IF/ID
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem            : instruction-memory bus (master side)
//   stall           : decode cannot accept IF/ID this cycle
//   redirect        : taken B/BR, flush and refetch from redirect_pc
//   redirect_pc     : redirect target (bit 0 forced to 0)
//   pc              : current fetch PC
//   ifid_instr      : instruction presented to decode
//   ifid_pc_plus2   : PC+2 of ifid_instr
//   ifid_valid      : IF/ID holds a real instruction
//   hlt_fetched     : HLT fetched, fetch frozen
module fetch_stage
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = OP_HLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    output logic [15:0]          pc,
    output logic [15:0]          ifid_instr,
    output logic [15:0]          ifid_pc_plus2,
    output logic                 ifid_valid,
    output logic                 hlt_fetched
);

    localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  buf_q, buf_d;
    logic [15:0]  pc_plus2;
    logic         ifid_loadable;
    logic         ifid_load;
    logic         ifid_flush;
    logic [15:0]  ifid_instr_in;

    // Modular add: 16'hFFFE wraps to 16'h0000.
    assign pc_plus2      = pc_q + 16'd2;
    assign ifid_loadable = !ifid_valid || !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr_in = imem.imem_rdata;

        if (redirect) begin
            pc_d       = redirect_pc & 16'hFFFE;
            ifid_flush = 1'b1;
            buf_d      = NOP_INSTR;
            unique case (state_q)
                // Without a response this cycle the old request is still in
                // flight and must be drained before the new address is trusted.
                FETCH:   state_d = imem.imem_valid ? FETCH : DRAIN;
                DRAIN:   state_d = DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem.imem_valid) begin
                        pc_d = pc_plus2;
                        if (ifid_loadable) begin
                            ifid_load = 1'b1;
                            state_d   = opcode_is(imem.imem_rdata, HLT_OPCODE) ? HALT : FETCH;
                        end else begin
                            buf_d   = imem.imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    // pc already advanced past the buffered word, so pc_q is its PC+2.
                    if (!stall) begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = buf_q;
                        buf_d         = NOP_INSTR;
                        state_d       = opcode_is(buf_q, HLT_OPCODE) ? HALT : FETCH;
                    end
                end
                DRAIN: begin
                    ifid_flush = 1'b1;
                    if (imem.imem_valid) begin
                        state_d = FETCH;
                    end
                end
                HALT: begin
                    if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC_ALIGNED;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // In HOLD the next edge would use pc_q as PC+2, in FETCH it is pc_q+2.
    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ifid_load),
        .flush_i    (ifid_flush),
        .instr_i    (ifid_instr_in),
        .pc_plus2_i ((state_q == HOLD) ? pc_q : pc_plus2),
        .instr_o    (ifid_instr),
        .pc_plus2_o (ifid_pc_plus2),
        .valid_o    (ifid_valid)
    );

    assign imem.imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign hlt_fetched    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        hlt_fetched;

    int checks;
    int errors;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .hlt_fetched   (hlt_fetched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: responds in the lat-th cycle of a held request with the
    // word at the address presented in the request's first cycle.
    logic [15:0] mem [0:127];
    int          lat;
    int          cnt;
    logic [15:0] addr_cap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 0;
            addr_cap <= 16'h0000;
        end else if (bus.imem_req && !bus.imem_valid) begin
            if (cnt == 0) addr_cap <= bus.imem_addr;
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    assign bus.imem_valid = bus.imem_req && (cnt == lat - 1);
    assign bus.imem_rdata = (cnt == 0) ? mem[bus.imem_addr[7:1]] : mem[addr_cap[7:1]];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0000); end
        checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp %h", ifid_instr, 16'h0000); end
        checks++; if (ifid_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL reset_pcp2 got %h exp %h", ifid_pc_plus2, 16'h0000); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
        checks++; if (hlt_fetched !== 1'b0) begin errors++; $display("FAIL reset_hlt got %b exp 0", hlt_fetched); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", bus.imem_req); end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        lat = 1;
        do_reset();
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL fetch_addr0 got %h exp %h", bus.imem_addr, 16'h0000); end
        @(negedge clk);
        checks++; if (bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL fetch_addr2 got %h exp %h", bus.imem_addr, 16'h0002); end
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h1234, 16'h0002, 1'b1}) begin
            errors++; $display("FAIL fetch_ifid1 got %h/%h/%b exp 1234/0002/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
        @(negedge clk);
        checks++; if (bus.imem_addr !== 16'h0004) begin errors++; $display("FAIL fetch_addr4 got %h exp %h", bus.imem_addr, 16'h0004); end
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h5678, 16'h0004, 1'b1}) begin
            errors++; $display("FAIL fetch_ifid2 got %h/%h/%b exp 5678/0004/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
    endtask

    task automatic test_stall();
        lat = 1;
        mem[1] = 16'hABCD;
        mem[2] = 16'h5678;
        do_reset();
        @(negedge clk);
        checks++; if ({ifid_instr, ifid_valid} !== {16'h1234, 1'b1}) begin
            errors++; $display("FAIL stall_pre got %h/%b exp 1234/1", ifid_instr, ifid_valid); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b exp 0", i, bus.imem_req); end
            checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL stall_pc%0d got %h exp %h", i, pc, 16'h0004); end
            checks++; if ({ifid_instr, ifid_valid} !== {16'h1234, 1'b1}) begin
                errors++; $display("FAIL stall_ifid%0d got %h/%b exp 1234/1", i, ifid_instr, ifid_valid); end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'hABCD, 16'h0004, 1'b1}) begin
            errors++; $display("FAIL stall_release got %h/%h/%b exp abcd/0004/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
        checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0004}) begin
            errors++; $display("FAIL stall_resume got %b/%h exp 1/0004", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h5678, 16'h0006, 1'b1}) begin
            errors++; $display("FAIL stall_next got %h/%h/%b exp 5678/0006/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
    endtask

    task automatic test_drain();
        lat = 3;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0040}) begin
            errors++; $display("FAIL drain_addr got %b/%h exp 1/0040", bus.imem_req, bus.imem_addr); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drain_bubble%0d got %b exp 0", i, ifid_valid); end
            if (i == 2) begin
                checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL drain_refetch got %h exp 0040", bus.imem_addr); end
            end
            @(negedge clk);
        end
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h4040, 16'h0042, 1'b1}) begin
            errors++; $display("FAIL drain_data got %h/%h/%b exp 4040/0042/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
    endtask

    task automatic test_async_reset();
        lat = 3;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL areset_pc got %h exp 0000", pc); end
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h0000, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL areset_ifid got %h/%h/%b exp 0000/0000/0", ifid_instr, ifid_pc_plus2, ifid_valid); end
        checks++; if ({hlt_fetched, bus.imem_req} !== 2'b01) begin
            errors++; $display("FAIL areset_ctl got %b/%b exp 0/1", hlt_fetched, bus.imem_req); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        lat = 1;
        mem[0] = 16'h1000;
        mem[1] = 16'h2000;
        mem[2] = 16'h3000;
        mem[3] = 16'hF000;
        mem[8] = 16'h4444;
        do_reset();
        repeat (4) @(negedge clk);
        checks++; if (hlt_fetched !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", hlt_fetched); end
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL halt_pc got %h exp 0008", pc); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %b exp 0", bus.imem_req); end
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'hF000, 16'h0008, 1'b1}) begin
            errors++; $display("FAIL halt_ifid got %h/%h/%b exp f000/0008/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
        @(negedge clk);
        checks++; if ({ifid_valid, pc} !== {1'b0, 16'h0008}) begin
            errors++; $display("FAIL halt_frozen got %b/%h exp 0/0008", ifid_valid, pc); end
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if ({hlt_fetched, pc, bus.imem_req, bus.imem_addr} !== {1'b0, 16'h0010, 1'b1, 16'h0010}) begin
            errors++; $display("FAIL halt_exit got %b/%h/%b/%h exp 0/0010/1/0010", hlt_fetched, pc, bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h4444, 16'h0012, 1'b1}) begin
            errors++; $display("FAIL halt_resume got %h/%h/%b exp 4444/0012/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
    endtask

    task automatic test_redirect_stall();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0021;
        @(negedge clk);
        stall    = 1'b0;
        redirect = 1'b0;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b exp 0", ifid_valid); end
        checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL rs_pc got %h exp 0020", pc); end
    endtask

    task automatic test_wrap();
        lat = 1;
        mem[0]   = 16'h1234;
        mem[127] = 16'h7777;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (bus.imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr got %h exp fffe", bus.imem_addr); end
        @(negedge clk);
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
        checks++; if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'h7777, 16'h0000, 1'b1}) begin
            errors++; $display("FAIL wrap_ifid got %h/%h/%b exp 7777/0000/1", ifid_instr, ifid_pc_plus2, ifid_valid); end
        lat = 3;
        repeat (3) @(negedge clk);
        checks++; if ({pc, ifid_instr, ifid_valid} !== {16'h0002, 16'h1234, 1'b1}) begin
            errors++; $display("FAIL wrap_slow got %h/%h/%b exp 0002/1234/1", pc, ifid_instr, ifid_valid); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        lat         = 1;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h1234;
        mem[1]  = 16'h5678;
        mem[32] = 16'h4040;

        test_reset();
        test_fetch();
        test_stall();
        test_drain();
        test_halt();
        test_redirect_stall();
        test_wrap();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
